// File: rtl/afifo_pkt_writer.sv
// afifo_pkt_writer: write-side packet framer in front of an async FIFO write port.
// Emits a {4'hA, seq} header, the payload words, and, when AFIFO_PKT_CSUM_EN is
// defined, a modulo-2^WIDTH checksum trailer. Over-length packets are cut at
// MAX_LEN words and their remainder is swallowed.
// Build option: `define AFIFO_PKT_CSUM_EN to enable the checksum trailer.
module afifo_pkt_writer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             wclk,
    input  logic             wrstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             fifo_wfull,
    output logic             fifo_winc,
    output logic [WIDTH-1:0] fifo_wdata,
    output logic             busy,
    output logic             trunc_err,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam int unsigned SEQ_W = WIDTH - 4;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

`ifdef AFIFO_PKT_CSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2,
        DROP    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd3
    } state_t;
`endif

    state_t           state;
    logic [SEQ_W-1:0] seq;
    logic [LEN_W-1:0] len;
`ifdef AFIFO_PKT_CSUM_EN
    logic [WIDTH-1:0] csum;
    logic             trunc_pend;
`endif

    logic accept;
    logic at_max;
    logic pkt_end;
    logic trunc_now;

    assign accept    = in_valid & in_ready;
    assign at_max    = (len == LEN_LAST);
    assign pkt_end   = accept & (in_last | at_max);
    assign trunc_now = accept & at_max & ~in_last;
    assign busy      = (state != IDLE);

    // FIFO strobe, write data and upstream ready decoded from the current state
    always_comb begin
        in_ready   = 1'b0;
        fifo_winc  = 1'b0;
        fifo_wdata = '0;
        case (state)
            IDLE: begin
                fifo_winc = in_valid & ~fifo_wfull;
                if (fifo_winc) fifo_wdata = {4'hA, seq};
            end
            PAYLOAD: begin
                in_ready  = ~fifo_wfull;
                fifo_winc = in_valid & ~fifo_wfull;
                if (fifo_winc) fifo_wdata = in_data;
            end
`ifdef AFIFO_PKT_CSUM_EN
            TRAILER: begin
                fifo_winc = ~fifo_wfull;
                if (fifo_winc) fifo_wdata = csum;
            end
`endif
            DROP: begin
                in_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Framing state, sequence number, length/checksum accumulators and status
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state      <= IDLE;
            seq        <= '0;
            len        <= '0;
            trunc_err  <= 1'b0;
            pkt_cnt    <= '0;
`ifdef AFIFO_PKT_CSUM_EN
            csum       <= '0;
            trunc_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_winc) begin
                        seq   <= seq + SEQ_W'(1);
                        len   <= '0;
`ifdef AFIFO_PKT_CSUM_EN
                        csum  <= '0;
`endif
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        len <= len + LEN_W'(1);
`ifdef AFIFO_PKT_CSUM_EN
                        csum <= csum + in_data;
`endif
                        if (trunc_now) trunc_err <= 1'b1;
                        if (pkt_end) begin
`ifdef AFIFO_PKT_CSUM_EN
                            trunc_pend <= trunc_now;
                            state      <= TRAILER;
`else
                            pkt_cnt <= pkt_cnt + CNT_W'(1);
                            state   <= trunc_now ? DROP : IDLE;
`endif
                        end
                    end
                end
`ifdef AFIFO_PKT_CSUM_EN
                TRAILER: begin
                    if (!fifo_wfull) begin
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                        state   <= trunc_pend ? DROP : IDLE;
                    end
                end
`endif
                DROP: begin
                    if (accept && in_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_pkt_writer.sv
// Bench for afifo_pkt_writer: packet-level model of the expected FIFO word
// stream, a per-cycle compare process, and literal expectations per scenario.
module tb_afifo_pkt_writer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 16;
`ifdef AFIFO_PKT_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic             wclk       = 1'b0;
    logic             wrstn      = 1'b0;
    logic             in_valid   = 1'b0;
    logic             in_last    = 1'b0;
    logic [WIDTH-1:0] in_data    = '0;
    logic             fifo_wfull = 1'b0;
    logic             in_ready;
    logic             fifo_winc;
    logic [WIDTH-1:0] fifo_wdata;
    logic             busy;
    logic             trunc_err;
    logic [CNT_W-1:0] pkt_cnt;

    afifo_pkt_writer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .wclk       (wclk),
        .wrstn      (wrstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .fifo_wfull (fifo_wfull),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .trunc_err  (trunc_err),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // packet-level model state
    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    logic [7:0] ref_q[$];
    int         seq_m = 0;
    int         cnt_m = 0;
    bit         trunc_m = 1'b0;
    logic [7:0] pkt[16];

    logic [7:0] lit_t1[5] = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h66};
    logic [7:0] lit_tr[6] = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected FIFO words for one packet of n words taken from pkt[]
    task automatic model_pkt(input int n);
        logic [7:0] s;
        int m;
        s = 8'h00;
        m = (n > int'(MAX_LEN)) ? int'(MAX_LEN) : n;
        exp_q.push_back({4'hA, 4'(seq_m)});
        seq_m = (seq_m + 1) % 16;
        for (int i = 0; i < m; i++) begin
            exp_q.push_back(pkt[i]);
            s = s + pkt[i];
        end
        if (CSUM) exp_q.push_back(s);
        cnt_m++;
        if (n > int'(MAX_LEN)) trunc_m = 1'b1;
    endtask

    // Compare every FIFO write against the model stream
    always @(negedge wclk) begin
        if (wrstn) begin
            if (fifo_winc) begin
                chk("winc_while_full", 32'(fifo_wfull), 32'd0);
                seen_q.push_back(fifo_wdata);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_wdata);
                end else begin
                    chk("fifo_word", 32'(fifo_wdata), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("wdata_idle_zero", 32'(fifo_wdata), 32'd0);
            end
        end
    end

    // Drive one packet from pkt[0..n-1]; optionally stall 5 cycles after word stall_after
    task automatic send_pkt(input int n, input int stall_after);
        int   i;
        int   stall;
        int   guard;
        logic acc;
        i = 0;
        stall = 0;
        guard = 0;
        while (i < n && guard < 200) begin
            in_valid   = 1'b1;
            in_data    = pkt[i];
            in_last    = (i == n - 1);
            fifo_wfull = (stall > 0);
            @(negedge wclk);
            if (stall > 0) begin
                chk("stall_winc", 32'(fifo_winc), 32'd0);
                chk("stall_ready", 32'(in_ready), 32'd0);
            end
            acc = in_ready;
            @(posedge wclk);
            #1;
            if (stall > 0) stall--;
            if (acc) begin
                if (i == stall_after) stall = 5;
                i++;
            end
            guard++;
        end
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: accepted %0d words expected %0d", i, n);
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        fifo_wfull = 1'b0;
    endtask

    // Wait (bounded) for busy to drop, check status against the model, realign
    task automatic wait_idle(input string name);
        int g;
        g = 0;
        @(negedge wclk);
        while (busy && g < 20) begin
            @(negedge wclk);
            g++;
        end
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(cnt_m));
        chk({name, "_trunc_err"}, 32'(trunc_err), 32'(trunc_m));
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        fifo_wfull = 1'b0;
        #1 wrstn = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_winc", 32'(fifo_winc), 32'd0);
        chk("rst_wdata", 32'(fifo_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trunc_err", 32'(trunc_err), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        exp_q.delete();
        seq_m   = 0;
        cnt_m   = 0;
        trunc_m = 1'b0;
        @(posedge wclk);
        #1 wrstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int stride;
        repeat (2) @(posedge wclk);
        #1;
        do_reset();

        // Basic packet 0x11, 0x22, 0x33
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        seen_q.delete();
        model_pkt(3);
        send_pkt(3, -1);
        wait_idle("basic");
        n = CSUM ? 5 : 4;
        chk("basic_words", 32'(seen_q.size()), 32'(n));
        for (int i = 0; i < n; i++) chk("basic_lit", 32'(seen_q[i]), 32'(lit_t1[i]));

        // 17 back-to-back one-word packets: sequence wrap
        do_reset();
        seen_q.delete();
        for (int k = 0; k < 17; k++) begin
            pkt[0] = 8'(8'h40 + k);
            model_pkt(1);
            send_pkt(1, -1);
        end
        wait_idle("b2b");
        stride = CSUM ? 3 : 2;
        chk("b2b_words", 32'(seen_q.size()), 32'(17 * stride));
        for (int k = 0; k < 17; k++)
            chk("b2b_hdr", 32'(seen_q[k * stride]), 32'(8'hA0 | 8'(k % 16)));
        chk("b2b_cnt_lit", 32'(pkt_cnt), 32'd17);

        // 4-word packet (last on MAX_LEN-th word), unstalled then stalled
        pkt[0] = 8'h10; pkt[1] = 8'h20; pkt[2] = 8'h30; pkt[3] = 8'h40;
        seen_q.delete();
        model_pkt(4);
        send_pkt(4, -1);
        wait_idle("nostall");
        ref_q = seen_q;
        seen_q.delete();
        model_pkt(4);
        send_pkt(4, 1);
        wait_idle("stall");
        chk("stall_words", 32'(seen_q.size()), 32'(ref_q.size()));
        for (int i = 1; i < ref_q.size(); i++)
            chk("stall_same_word", 32'(seen_q[i]), 32'(ref_q[i]));
        chk("maxlen_last_no_trunc", 32'(trunc_err), 32'd0);

        // Over-length packet 1..6 with MAX_LEN=4
        do_reset();
        for (int i = 0; i < 6; i++) pkt[i] = 8'(i + 1);
        seen_q.delete();
        model_pkt(6);
        send_pkt(6, -1);
        wait_idle("trunc");
        n = CSUM ? 6 : 5;
        chk("trunc_words", 32'(seen_q.size()), 32'(n));
        for (int i = 0; i < n; i++) chk("trunc_lit", 32'(seen_q[i]), 32'(lit_tr[i]));
        chk("trunc_err_lit", 32'(trunc_err), 32'd1);
        pkt[0] = 8'h99;
        seen_q.delete();
        model_pkt(1);
        send_pkt(1, -1);
        wait_idle("after_trunc");
        chk("after_trunc_hdr", 32'(seen_q[0]), 32'h0A1);
        chk("trunc_err_sticky", 32'(trunc_err), 32'd1);

        // Reset in the middle of PAYLOAD
        pkt[0] = 8'h77; pkt[1] = 8'h78; pkt[2] = 8'h79;
        model_pkt(3);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b0;
        @(posedge wclk);
        #1;
        @(posedge wclk);
        #1;
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset();
        pkt[0] = 8'h5A;
        seen_q.delete();
        model_pkt(1);
        send_pkt(1, -1);
        wait_idle("post_reset");
        chk("post_reset_hdr", 32'(seen_q[0]), 32'h0A0);

        repeat (3) @(posedge wclk);
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
